// File: rtl/key_pkg.sv
// Shared constants and helpers for the push-button front end.
package key_pkg;

    localparam bit EV_PRESS      = 1'b0;
    localparam bit EV_LONG       = 1'b1;
    localparam int KEY_N_DEFAULT = 5;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/key_filter.sv
// Per-key 2-FF synchroniser, stable-sample debouncer and long-hold counter.
// Event pulses are combinational on the tick that changes state; no backpressure.
module key_filter
    import key_pkg::*;
#(
    parameter int STABLE_SAMPLES = 20,
    parameter int LONG_SAMPLES   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_evt,
    output logic long_evt
);

    localparam int SW = clog2_min1(STABLE_SAMPLES);
    localparam int HW = clog2_min1(LONG_SAMPLES);
    localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_SAMPLES - 2);

    logic          sync1;
    logic          sync2;
    logic [SW-1:0] cnt;
    logic [HW-1:0] hold;

    // Pulses coincide with the edge that flips level / saturates hold.
    assign press_evt = tick && !level && sync2 && (cnt == CNT_LAST);
    assign long_evt  = tick && level && (hold == HOLD_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            hold  <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (!level) begin
                hold <= '0;
            end else if (tick && (hold != HOLD_MAX)) begin
                hold <= hold + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Debounces N keys and serialises press/long-press events round-robin onto one valid/ready port.
// Pending bit to ev_valid is one cycle; the output slot holds while ev_valid && !ev_ready.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int N_KEYS         = KEY_N_DEFAULT,
    parameter int SAMPLE_DIV     = 100_000,
    parameter int STABLE_SAMPLES = 20,
    parameter int LONG_SAMPLES   = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         key_raw,
    input  logic                      ev_ready,
    output logic                      ev_valid,
    output logic [$clog2(N_KEYS)-1:0] ev_id,
    output logic                      ev_long,
    output logic [N_KEYS-1:0]         key_level,
    output logic                      overrun
);

    localparam int IW = $clog2(N_KEYS);
    localparam int DW = clog2_min1(SAMPLE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [DW-1:0]     div_cnt;
    logic              tick;
    logic [N_KEYS-1:0] press_evt;
    logic [N_KEYS-1:0] long_evt;
    logic [N_KEYS-1:0] press_pend;
    logic [N_KEYS-1:0] long_pend;
    logic [N_KEYS-1:0] press_clr;
    logic [N_KEYS-1:0] long_clr;
    logic [N_KEYS-1:0] req;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_found;
    logic              load;
    logic [IW:0]       scan;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_filter #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_SAMPLES   (LONG_SAMPLES)
        ) u_filter (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .raw       (key_raw[i]),
            .level     (key_level[i]),
            .press_evt (press_evt[i]),
            .long_evt  (long_evt[i])
        );
    end

    assign req  = press_pend | long_pend;
    assign load = !ev_valid || ev_ready;

    // Scan starts one past the last winner; scan is wide enough for rr_ptr + N_KEYS.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 1; k <= N_KEYS; k++) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(N_KEYS)) begin
                scan = scan - (IW+1)'(N_KEYS);
            end
            if (!gnt_found && req[scan[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        press_clr = '0;
        long_clr  = '0;
        if (load && gnt_found) begin
            if (press_pend[gnt_idx]) begin
                press_clr[gnt_idx] = 1'b1;
            end else begin
                long_clr[gnt_idx] = 1'b1;
            end
        end
    end

    // A new event beats a same-cycle grant clear; only a set onto a still-held bit is a loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_pend <= '0;
            long_pend  <= '0;
            overrun    <= 1'b0;
        end else begin
            press_pend <= press_evt | (press_pend & ~press_clr);
            long_pend  <= long_evt | (long_pend & ~long_clr);
            if (|((press_evt & press_pend & ~press_clr) | (long_evt & long_pend & ~long_clr))) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_id    <= '0;
            ev_long  <= 1'b0;
            rr_ptr   <= IW'(N_KEYS - 1);
        end else if (load) begin
            ev_valid <= gnt_found;
            if (gnt_found) begin
                ev_id   <= gnt_idx;
                ev_long <= press_pend[gnt_idx] ? EV_PRESS : EV_LONG;
                rr_ptr  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter with a cycle reference model, vector table and directed corner cases.
module tb_key_event_arbiter;

    localparam int N  = 5;
    localparam int SD = 4;
    localparam int ST = 3;
    localparam int LG = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_raw;
    logic         ev_ready;
    logic         ev_valid;
    logic [2:0]   ev_id;
    logic         ev_long;
    logic [N-1:0] key_level;
    logic         overrun;

    always #5 clk = ~clk;

    key_event_arbiter #(
        .N_KEYS         (N),
        .SAMPLE_DIV     (SD),
        .STABLE_SAMPLES (ST),
        .LONG_SAMPLES   (LG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_id     (ev_id),
        .ev_long   (ev_long),
        .key_level (key_level),
        .overrun   (overrun)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-key sample history expressed as counts of ticks.
    int m_div;
    int m_s1[N], m_s2[N], m_lvl[N], m_cnt[N], m_hold[N];
    bit m_pp[N], m_lp[N];
    int m_v, m_id, m_long, m_rr, m_ovr;

    task automatic model_step();
        bit tick;
        bit pe[N];
        bit le[N];
        int rr0;
        bit found;
        int j;
        if (rst) begin
            m_div = 0;
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
                m_pp[i] = 0; m_lp[i] = 0;
            end
            m_v = 0; m_id = 0; m_long = 0; m_ovr = 0; m_rr = N - 1;
        end else begin
            tick  = (m_div == SD - 1);
            m_div = tick ? 0 : m_div + 1;
            for (int i = 0; i < N; i++) begin
                pe[i] = 0;
                le[i] = 0;
                if (m_lvl[i] == 0) m_hold[i] = 0;
                else if (tick && m_hold[i] < LG - 1) begin
                    m_hold[i]++;
                    le[i] = (m_hold[i] == LG - 1);
                end
                if (tick) begin
                    if (m_s2[i] == m_lvl[i]) m_cnt[i] = 0;
                    else if (m_cnt[i] == ST - 1) begin
                        m_lvl[i] = 1 - m_lvl[i];
                        m_cnt[i] = 0;
                        pe[i]    = (m_lvl[i] == 1);
                    end else m_cnt[i]++;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = key_raw[i];
            end
            if (!m_v || ev_ready) begin
                m_v   = 0;
                rr0   = m_rr;
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    j = (rr0 + k) % N;
                    if (!found && (m_pp[j] || m_lp[j])) begin
                        found  = 1;
                        m_v    = 1;
                        m_id   = j;
                        m_long = m_pp[j] ? 0 : 1;
                        if (m_pp[j]) m_pp[j] = 0;
                        else m_lp[j] = 0;
                        m_rr = j;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (pe[i]) begin
                    if (m_pp[i]) m_ovr = 1;
                    m_pp[i] = 1;
                end
                if (le[i]) begin
                    if (m_lp[i]) m_ovr = 1;
                    m_lp[i] = 1;
                end
            end
        end
    endtask

    int n_acc;
    int acc_ids[$];
    int acc_longs[$];

    task automatic clear_log();
        n_acc = 0;
        acc_ids.delete();
        acc_longs.delete();
    endtask

    task automatic step();
        logic [N-1:0] mlv;
        if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
            n_acc++;
            acc_ids.push_back(int'(ev_id));
            acc_longs.push_back(int'(ev_long));
        end
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < N; i++) mlv[i] = m_lvl[i][0];
        chk("model_key_level", key_level, mlv);
        chk("model_ev_valid", ev_valid, m_v);
        chk("model_overrun", overrun, m_ovr);
        if (m_v == 1) begin
            chk("model_ev_id", ev_id, m_id);
            chk("model_ev_long", ev_long, m_long);
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] raw;
        bit           rdy;
        int           cycles;
        logic [N-1:0] lvl;
        int           nev;
        int           id;
        int           lng;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int w;
        rst      = 1'b1;
        key_raw  = '0;
        ev_ready = 1'b1;

        tbl[0] = '{1'b1, 5'b00000, 1'b1, 3,  5'b00000, 0, 0, 0};
        tbl[1] = '{1'b0, 5'b00100, 1'b1, 8,  5'b00000, 0, 0, 0};  // two ticks only: filtered out
        tbl[2] = '{1'b0, 5'b00000, 1'b1, 8,  5'b00000, 0, 0, 0};
        tbl[3] = '{1'b0, 5'b00100, 1'b1, 16, 5'b00100, 1, 2, 0};
        tbl[4] = '{1'b0, 5'b00100, 1'b1, 32, 5'b00100, 1, 2, 1};
        tbl[5] = '{1'b0, 5'b00000, 1'b1, 20, 5'b00000, 0, 0, 0};
        tbl[6] = '{1'b0, 5'b11001, 1'b1, 16, 5'b11001, 3, 0, 0};  // rr_ptr=2, so order 3,4,0

        for (int i = 0; i < 7; i++) begin
            rst      = tbl[i].rst;
            key_raw  = tbl[i].raw;
            ev_ready = tbl[i].rdy;
            clear_log();
            run(tbl[i].cycles);
            chk($sformatf("tbl%0d_level", i), key_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_events", i), n_acc, tbl[i].nev);
            chk($sformatf("tbl%0d_overrun", i), overrun, 0);
            if (tbl[i].nev > 0 && acc_ids.size() > 0) begin
                chk($sformatf("tbl%0d_last_id", i), acc_ids[$], tbl[i].id);
                chk($sformatf("tbl%0d_last_long", i), acc_longs[$], tbl[i].lng);
            end
        end

        // Held event under backpressure, then one long-press.
        do_reset();
        key_raw  = 5'b00100;
        ev_ready = 1'b0;
        w = 0;
        while (ev_valid !== 1'b1 && w < 60) begin step(); w++; end
        chk("hold_valid_seen", ev_valid, 1);
        chk("hold_first_id", ev_id, 2);
        chk("hold_first_long", ev_long, 0);
        repeat (5) begin
            step();
            chk("hold_stable_valid", ev_valid, 1);
            chk("hold_stable_id", ev_id, 2);
            chk("hold_stable_long", ev_long, 0);
        end
        ev_ready = 1'b1;
        clear_log();
        step();
        chk("hold_accept_count", n_acc, 1);
        step();
        chk("hold_slot_empty", ev_valid, 0);
        clear_log();
        run(40);
        chk("long_count", n_acc, 1);
        if (acc_ids.size() > 0) begin
            chk("long_id", acc_ids[0], 2);
            chk("long_flag", acc_longs[0], 1);
        end
        clear_log();
        run(40);
        chk("long_no_repeat", n_acc, 0);

        // Round-robin from reset, then keys 0 and 3 with rr_ptr on key 4.
        do_reset();
        key_raw  = 5'b11001;
        ev_ready = 1'b1;
        clear_log();
        run(30);
        chk("rr_count", acc_ids.size(), 3);
        if (acc_ids.size() == 3) begin
            chk("rr_first", acc_ids[0], 0);
            chk("rr_second", acc_ids[1], 3);
            chk("rr_third", acc_ids[2], 4);
        end
        key_raw = 5'b00000;
        run(30);
        clear_log();
        key_raw = 5'b01001;
        run(24);
        chk("rr2_count", acc_ids.size(), 2);
        if (acc_ids.size() == 2) begin
            chk("rr2_first", acc_ids[0], 0);
            chk("rr2_second", acc_ids[1], 3);
        end

        // Overrun: key1 pends behind a stalled key0 event and is pressed again.
        do_reset();
        key_raw  = 5'b00001;
        ev_ready = 1'b0;
        run(20);
        chk("ovr_slot_id", ev_id, 0);
        key_raw = 5'b00011;
        run(20);
        chk("ovr_not_yet", overrun, 0);
        key_raw = 5'b00001;
        run(20);
        key_raw = 5'b00011;
        run(20);
        chk("ovr_set", overrun, 1);
        ev_ready = 1'b1;
        clear_log();
        run(20);
        w = 0;
        foreach (acc_ids[k]) if (acc_ids[k] == 1 && acc_longs[k] == 0) w++;
        chk("ovr_single_key1", w, 1);
        chk("ovr_sticky", overrun, 1);

        // Reset mid-operation with an event in flight.
        do_reset();
        key_raw  = 5'b00100;
        ev_ready = 1'b0;
        run(20);
        chk("rst_pre_valid", ev_valid, 1);
        rst = 1'b1;
        step();
        chk("rst_valid", ev_valid, 0);
        chk("rst_level", key_level, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        w = 0;
        while (key_level[2] !== 1'b1 && w < 40) begin step(); w++; end
        chk("rst_redetect_cycles", w, 12);

        // Random keys and backpressure against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) key_raw[i] = ~key_raw[i];
            ev_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
